// File: rtl/multi_add_seq_if.sv
// Client-side request/response bundle for multi_add_seq; WORDS sets operand width.
// Optional rsp_z/rsp_n flags appear only when MULTI_ADD_FLAGS_EN is defined.
// Handshake: valid/ready on both the request and the response channel.
interface multi_add_seq_if #(
    parameter int WORDS = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_sub;
    logic [32*WORDS-1:0]   req_a;
    logic [32*WORDS-1:0]   req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [32*WORDS-1:0]   rsp_s;
    logic                  rsp_co;
    logic                  rsp_ovf;
`ifdef MULTI_ADD_FLAGS_EN
    logic                  rsp_z;
    logic                  rsp_n;

    modport master (
        output req_valid, req_sub, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_s, rsp_co, rsp_ovf, rsp_z, rsp_n
    );
    modport slave (
        input  req_valid, req_sub, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_s, rsp_co, rsp_ovf, rsp_z, rsp_n
    );
`else
    modport master (
        output req_valid, req_sub, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_s, rsp_co, rsp_ovf
    );
    modport slave (
        input  req_valid, req_sub, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_s, rsp_co, rsp_ovf
    );
`endif
endinterface

// File: rtl/multi_add_seq.sv
// Multi-precision add/sub over a shared 32-bit CLA, one word per cycle LSW first (MULTI_ADD_FLAGS_EN adds rsp_z/rsp_n).
// Latency: accept in cycle T, rsp_valid (registered) in cycle T+WORDS+1.
// Backpressure: one op in flight; result held in DONE until rsp_ready, req_ready only in IDLE.
module multi_add_seq #(
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    multi_add_seq_if.slave bus,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_ci,
    input  logic        add_g,
    input  logic        add_p,
    input  logic [31:0] add_s
);
    localparam int W  = 32 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, b_q, s_q;
    logic            sub_q, carry_q, co_q, ovf_q;
    logic [IW-1:0]   idx_q;
    logic            req_ready, rsp_valid, carry_nxt, last;

    assign last      = (idx_q == LAST);
    assign carry_nxt = add_g | (add_p & carry_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Adder inputs are forced to zero outside RUN so the shared CLA stays quiet.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        add_a     = 32'd0;
        add_b     = 32'd0;
        add_ci    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) state_d = RUN;
            end
            RUN: begin
                add_a  = a_q[{idx_q, 5'd0} +: 32];
                add_b  = b_q[{idx_q, 5'd0} +: 32] ^ {32{sub_q}};
                add_ci = carry_q;
                if (last) state_d = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else if (state_q == IDLE && bus.req_valid) begin
            a_q     <= bus.req_a;
            b_q     <= bus.req_b;
            sub_q   <= bus.req_sub;
            carry_q <= bus.req_sub;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            s_q[{idx_q, 5'd0} +: 32] <= add_s;
            carry_q <= carry_nxt;
            if (last) begin
                co_q  <= carry_nxt;
                // Signed overflow: operands agree in sign but the top word's sum does not.
                ovf_q <= (add_a[31] == add_b[31]) && (add_s[31] != add_a[31]);
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

`ifdef MULTI_ADD_FLAGS_EN
    logic z_q;

    // Zero flag built word by word; word 0 restarts the accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                z_q <= 1'b0;
        else if (state_q == RUN)   z_q <= ((idx_q == '0) ? 1'b1 : z_q) & ~(|add_s);
    end

    assign bus.rsp_z = z_q;
    assign bus.rsp_n = s_q[W-1];
`endif

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_s     = s_q;
    assign bus.rsp_co    = co_q;
    assign bus.rsp_ovf   = ovf_q;
endmodule
